// File: rtl/sine_freq_meter.sv
// Sine-input frequency meter: times 16 sine periods and divides to recover
// the DDS phase-accumulator tuning word that would produce that frequency.
module sine_freq_meter #(
  parameter int ACC_W     = 26,
  parameter int GATE_LOG2 = 4,
  parameter int CNT_W     = 32,
  parameter int MIDSCALE  = 512,
  parameter int HYST      = 16
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_enable,
  input  logic [9:0]       i_sine_wave,
  output logic [ACC_W-1:0] o_freq_word,
  output logic             o_word_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam int NUM_W  = ACC_W + GATE_LOG2 + 1;
  localparam int STEP_W = $clog2(NUM_W);
  localparam int PER_W  = GATE_LOG2 + 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_W - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'((1 << GATE_LOG2) - 1);
  localparam logic [9:0]        HI_TH     = 10'(MIDSCALE + HYST);
  localparam logic [9:0]        LO_TH     = 10'(MIDSCALE - HYST);

  typedef enum logic [1:0] {
    ARM,
    MEASURE,
    DIVIDE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [9:0]        s1;
  logic              sq;
  logic              sq_d;
  logic              rise;

  logic [CNT_W-1:0]  cnt;
  logic [PER_W-1:0]  per;
  logic [CNT_W-1:0]  c_reg;
  logic [CNT_W-1:0]  rem;
  logic [NUM_W-1:0]  quo;
  logic [STEP_W-1:0] step;

  logic              cnt_max;
  logic              to_hit;
  logic              start;
  logic              close;
  logic              div_done;

  logic              num_bit;
  logic [CNT_W:0]    rem_sh;
  logic              ge;
  logic [CNT_W-1:0]  rem_nx;
  logic [NUM_W-1:0]  quo_nx;
  logic              sat;

  // Comparator with hysteresis; holds inside the dead band
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      s1   <= '0;
      sq   <= 1'b0;
      sq_d <= 1'b0;
    end else begin
      s1   <= i_sine_wave;
      sq_d <= sq;
      if (s1 >= HI_TH)
        sq <= 1'b1;
      else if (s1 <= LO_TH)
        sq <= 1'b0;
    end
  end

  assign rise    = sq & ~sq_d;
  assign cnt_max = &cnt;
  assign o_busy  = (state != ARM);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst)
      state <= ARM;
    else
      state <= state_nx;
  end

  // Timeout is tested ahead of the edge so it wins a tie
  always_comb begin
    state_nx = state;
    to_hit   = 1'b0;
    start    = 1'b0;
    close    = 1'b0;
    div_done = 1'b0;
    if (!i_enable) begin
      state_nx = ARM;
    end else begin
      unique case (state)
        ARM: begin
          if (cnt_max) begin
            to_hit = 1'b1;
          end else if (rise) begin
            start    = 1'b1;
            state_nx = MEASURE;
          end
        end
        MEASURE: begin
          if (cnt_max) begin
            to_hit   = 1'b1;
            state_nx = ARM;
          end else if (rise && per == PER_LAST) begin
            close    = 1'b1;
            state_nx = DIVIDE;
          end
        end
        DIVIDE: begin
          if (step == STEP_LAST) begin
            div_done = 1'b1;
            state_nx = ARM;
          end
        end
        default: state_nx = ARM;
      endcase
    end
  end

  // Numerator is 2^(NUM_W-1): only its leading bit is set
  assign num_bit = (step == '0);
  assign rem_sh  = {rem, num_bit};
  assign ge      = (rem_sh >= {1'b0, c_reg});
  assign rem_nx  = ge ? CNT_W'(rem_sh - {1'b0, c_reg})
                      : rem_sh[CNT_W-1:0];
  assign quo_nx  = {quo[NUM_W-2:0], ge};
  assign sat     = |quo_nx[NUM_W-1:ACC_W];

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      cnt          <= '0;
      per          <= '0;
      c_reg        <= '0;
      rem          <= '0;
      quo          <= '0;
      step         <= '0;
      o_freq_word  <= '0;
      o_word_valid <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      o_timeout    <= to_hit;

      if (!i_enable) begin
        cnt <= '0;
        per <= '0;
      end else if (to_hit) begin
        cnt <= '0;
      end else if (start) begin
        cnt <= '0;
        per <= '0;
      end else if (state == DIVIDE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (state == MEASURE && rise)
          per <= per + 1'b1;
      end

      if (close) begin
        c_reg <= cnt + 1'b1;
        rem   <= '0;
        quo   <= '0;
        step  <= '0;
      end else if (state == DIVIDE && i_enable) begin
        rem  <= rem_nx;
        quo  <= quo_nx;
        step <= step + 1'b1;
      end

      if (div_done) begin
        o_word_valid <= 1'b1;
        o_freq_word  <= sat ? '1 : quo_nx[ACC_W-1:0];
      end
    end
  end

endmodule

// File: doc/sine_freq_meter.md
# sine_freq_meter

Frequency meter for the DDS sine output: samples the 10-bit sine stream, measures the period over a fixed number of cycles, and returns the 26-bit phase-accumulator word that would regenerate that frequency. It sits on the same `i_sys_clk` domain as the DDS. Loop-back (`dds` output → `sine_freq_meter` input) must return the programmed tuning word.

## Interface
- `ACC_W`, 26: phase-accumulator width; output word width.
- `GATE_LOG2`, 4: log2 of the number of sine periods per measurement (N = 2^GATE_LOG2 = 16).
- `CNT_W`, 32: width of the cycle counter and the timeout limit.
- `MIDSCALE`, 512: zero level of the offset-binary input.
- `HYST`, 16: comparator hysteresis in LSBs.
- `i_sys_clk`  in  1: system clock. Single clock domain.
- `i_sys_rst`  in  1: asynchronous, active-high reset.
- `i_enable`  in  1: measurement enable.
- `i_sine_wave`  in  10: unsigned offset-binary sample, one per clock.
- `o_freq_word`  out  ACC_W: last measured tuning word; holds between updates.
- `o_word_valid`  out  1: one-cycle pulse when `o_freq_word` updates.
- `o_timeout`  out  1: one-cycle pulse when a measurement is abandoned.
- `o_busy`  out  1: high in MEASURE or DIVIDE.

## Operation
**Front end**
- `i_sine_wave` is registered into `s1`.
- The square register `sq` sets when `s1 >= MIDSCALE+HYST` and clears when `s1 <= MIDSCALE-HYST`. Otherwise it holds.
- `edge = sq & ~sq_d`, an upward crossing, one cycle wide.

**FSM: ARM / MEASURE / DIVIDE**
- **ARM**
  - `cnt` increments each cycle.
  - On `edge`: `cnt <= 0`, `per <= 0`, go to MEASURE.
- **MEASURE**
  - `cnt` increments each cycle.
  - Each `edge` increments `per`.
  - On the edge that makes `per == N`: latch `C = cnt+1` and go to DIVIDE.
- **DIVIDE**
  - Restoring divider, 1 quotient bit per cycle, ACC_W+GATE_LOG2+1 = 31 cycles.
  - Computes `Q = floor(2^(ACC_W+GATE_LOG2) / C)`.
  - If `Q > 2^ACC_W-1`, `o_freq_word` saturates to all ones. Otherwise `o_freq_word <= Q[ACC_W-1:0]`.
  - Pulses `o_word_valid`, then returns to ARM.
  - Edges during DIVIDE are ignored.
- **Timeout:** in ARM or MEASURE, `cnt == 2^CNT_W-1` → pulse `o_timeout` and go to ARM with `cnt` cleared. `o_freq_word` is unchanged.
- **Enable low:** forces ARM immediately from any state, with `cnt`/`per` cleared. A divide in progress is discarded with no `o_word_valid`. `o_freq_word` holds.
- **Arithmetic:**
  - The numerator is a 31-bit constant (2^30 at defaults).
  - C ≥ 2N always, since hysteresis needs ≥ 2 samples per period, so division by zero cannot occur.
  - The quotient is truncated, not rounded.

## Timing
- **Reset values:**
  - All outputs are 0: `o_freq_word`, `o_word_valid`, `o_timeout`, `o_busy`.
  - `sq`, `sq_d`, `s1`, `cnt`, `per` and the divider registers are 0.
  - FSM is in ARM.
- **Input pipeline:** a sample crossing threshold at clock k sets `s1` at k+1, `sq` at k+2, and asserts `edge` during cycle k+2.
- **Latency:** with the final edge at cycle T, DIVIDE occupies T+1..T+31. `o_freq_word` and `o_word_valid` are registered at T+32.
- `o_busy` rises the cycle after the start edge and falls with `o_word_valid`.
- **Consecutive measurements:** the next window starts at the first edge seen after the return to ARM. Windows are therefore not back-to-back.
- **Simultaneous events:** the timeout compare and `edge` in the same cycle → timeout wins.
- **Reset mid-measurement:** asynchronous. All state returns to reset values at once.

## Test plan
- **Mid-rate word:** DDS loop-back with word 2^20 (64 cycles per period) → C = 1024. `o_freq_word = 1048576`, `o_word_valid` one cycle, 32 cycles after the 16th edge.
- **High rate:** DDS loop-back with word 2^24 (4 cycles per period) → C = 64, `o_freq_word = 16777216 - 0`, i.e. 2^24 exactly. No saturation.
- **Non-power-of-two word:** DDS loop-back with word 6711 (≈10000 cycles per period) → `o_freq_word` in 6710..6712 on every update over three consecutive measurements.
- **Timeout:** build with CNT_W=12 and hold input at 512 → `o_timeout` pulses every 4096 cycles. `o_word_valid` never asserts and `o_freq_word` keeps its prior value.
- **Hysteresis:** a ±10 LSB square dither around 512 superimposed on a word-2^20 sine produces no extra edges, and the result is still 1048576.
- **Abort paths:**
  - Assert `i_sys_rst` mid-MEASURE → all outputs 0 immediately.
  - Drop `i_enable` during DIVIDE → no `o_word_valid`, `o_busy` low the next cycle, `o_freq_word` unchanged.
